seq_engine: RTL and testbench

Game sequencer fed directly by the LFSR random-digit source. Pulses the RNG fetch strobe, captures one new digit per round into an internal sequence memory, then replays the whole sequence on the display outputs with fixed on/off timing. After replay it checks the player's keyed digits against the stored sequence and reports pass, fail or win.

---
 rtl/seq_engine.sv | 152 +++++++++++++++
 tb/tb_seq_engine.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_engine.sv
// seq_engine: memory-game sequencer.
// Fetches one RNG digit per round, replays the whole stored sequence with fixed
// on/off timing, then checks the player's entries and reports pass, fail or win.
// Optional feature macro: SEQ_DECIMAL_EN folds captured digits 10-15 down to 0-5.
module seq_engine #(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned LEN_W       = 5,
  parameter int unsigned SHOW_CYCLES = 25000000,
  parameter int unsigned GAP_CYCLES  = 12500000,
  parameter int unsigned TIMER_W     = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       rngDigit,
  output logic             rngFetchSignal,
  input  logic [3:0]       player_digit,
  input  logic             player_valid,
  output logic [3:0]       show_digit,
  output logic             show_en,
  output logic             input_ready,
  output logic [LEN_W-1:0] level,
  output logic             round_ok,
  output logic             fail,
  output logic             win
);

  localparam int unsigned IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  typedef enum logic [2:0] {
    StIdle, StFetch, StCapture, StShowOn, StShowOff, StInput, StFail, StWin
  } state_e;

  state_e             stateQ, stateD;
  logic [LEN_W-1:0]   levelQ, levelD;
  logic [LEN_W-1:0]   idxQ, idxD;
  logic [TIMER_W-1:0] timerQ, timerD;
  logic               roundOkQ, roundOkD;
  logic               memWe;
  logic [3:0]         capDigit;
  logic [3:0]         memRd;
  logic [3:0]         mem [MAX_LEN];

  // Digit as it will be stored in the sequence memory.
  always_comb begin
`ifdef SEQ_DECIMAL_EN
    capDigit = (rngDigit >= 4'd10) ? (rngDigit - 4'd10) : rngDigit;
`else
    capDigit = rngDigit;
`endif
  end

  assign memRd = mem[idxQ[IDX_W-1:0]];

  // Next-state logic; start overrides everything and restarts from level 0.
  always_comb begin
    stateD   = stateQ;
    levelD   = levelQ;
    idxD     = idxQ;
    timerD   = timerQ;
    roundOkD = 1'b0;
    memWe    = 1'b0;
    if (start) begin
      stateD = StFetch;
      levelD = '0;
      idxD   = '0;
    end else begin
      unique case (stateQ)
        StIdle: ;
        StFetch: stateD = StCapture;
        StCapture: begin
          memWe  = 1'b1;
          levelD = levelQ + LEN_W'(1);
          idxD   = '0;
          timerD = TIMER_W'(SHOW_CYCLES - 1);
          stateD = StShowOn;
        end
        StShowOn: begin
          if (timerQ == '0) begin
            timerD = TIMER_W'(GAP_CYCLES - 1);
            stateD = StShowOff;
          end else begin
            timerD = timerQ - TIMER_W'(1);
          end
        end
        StShowOff: begin
          if (timerQ != '0) begin
            timerD = timerQ - TIMER_W'(1);
          end else if (idxQ + LEN_W'(1) == levelQ) begin
            idxD   = '0;
            stateD = StInput;
          end else begin
            idxD   = idxQ + LEN_W'(1);
            timerD = TIMER_W'(SHOW_CYCLES - 1);
            stateD = StShowOn;
          end
        end
        StInput: begin
          if (player_valid) begin
            if (player_digit != memRd) begin
              stateD = StFail;
            end else if (idxQ == levelQ - LEN_W'(1)) begin
              roundOkD = 1'b1;
              stateD   = (levelQ == LEN_W'(MAX_LEN)) ? StWin : StFetch;
            end else begin
              idxD = idxQ + LEN_W'(1);
            end
          end
        end
        StFail, StWin: ;
        default: stateD = StIdle;
      endcase
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateQ   <= StIdle;
      levelQ   <= '0;
      idxQ     <= '0;
      timerQ   <= '0;
      roundOkQ <= 1'b0;
    end else begin
      stateQ   <= stateD;
      levelQ   <= levelD;
      idxQ     <= idxD;
      timerQ   <= timerD;
      roundOkQ <= roundOkD;
    end
  end

  // Sequence memory; never cleared since every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (rst && memWe) begin
      mem[levelQ[IDX_W-1:0]] <= capDigit;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    rngFetchSignal = (stateQ == StFetch);
    show_en        = (stateQ == StShowOn);
    show_digit     = (stateQ == StShowOn) ? memRd : 4'd0;
    input_ready    = (stateQ == StInput);
    fail           = (stateQ == StFail);
    win            = (stateQ == StWin);
    level          = levelQ;
    round_ok       = roundOkQ;
  end

endmodule

// File: tb/tb_seq_engine.sv
// Self-checking bench for seq_engine: small timing parameters, a stub RNG and a
// round-level reference model that expands each round into its expected timeline.
module tb_seq_engine;

  localparam int unsigned MaxLen = 3;
  localparam int unsigned LenW   = 2;
  localparam int unsigned ShowC  = 4;
  localparam int unsigned GapC   = 2;
  localparam int unsigned TimerW = 3;
`ifdef SEQ_DECIMAL_EN
  localparam logic [3:0] CExp = 4'd2;
`else
  localparam logic [3:0] CExp = 4'hC;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic            start = 1'b0;
  logic [3:0]      rngDigit = 4'd0;
  logic            rngFetchSignal;
  logic [3:0]      player_digit = 4'd0;
  logic            player_valid = 1'b0;
  logic [3:0]      show_digit;
  logic            show_en;
  logic            input_ready;
  logic [LenW-1:0] level;
  logic            round_ok;
  logic            fail;
  logic            win;

  always #5 clk = ~clk;

  seq_engine #(
    .MAX_LEN    (MaxLen),
    .LEN_W      (LenW),
    .SHOW_CYCLES(ShowC),
    .GAP_CYCLES (GapC),
    .TIMER_W    (TimerW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .rngDigit      (rngDigit),
    .rngFetchSignal(rngFetchSignal),
    .player_digit  (player_digit),
    .player_valid  (player_valid),
    .show_digit    (show_digit),
    .show_en       (show_en),
    .input_ready   (input_ready),
    .level         (level),
    .round_ok      (round_ok),
    .fail          (fail),
    .win           (win)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(string name, logic [15:0] got, logic [15:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Stub RNG: answers a fetch with a queued or random digit the next cycle, noise otherwise.
  int rngQ[$];
  always @(posedge clk) begin
    if (rngFetchSignal && rngQ.size() > 0) rngDigit <= 4'(rngQ.pop_front());
    else rngDigit <= 4'($urandom);
  end

  // Reference model: modes plus a per-cycle script of fetch/capture/show/gap events.
  localparam int MIdle = 0, MRun = 1, MInput = 2, MFail = 3, MWin = 4;
  localparam int KFetch = -1, KCap = -2, KGap = -3;
  int mode = MIdle;
  int script[$];
  int seq[$];
  int lvl = 0;
  int idx = 0;
  int cur = KGap;
  bit capNow = 0;
  bit pulse = 0;
  bit armed = 0;

  function automatic int mapDigit(int d);
`ifdef SEQ_DECIMAL_EN
    return (d >= 10) ? d - 10 : d;
`else
    return d;
`endif
  endfunction

  task automatic newRound();
    script.delete();
    script.push_back(KFetch);
    script.push_back(KCap);
    mode = MRun;
  endtask

  always @(posedge clk) begin
    pulse = 0;
    if (!rst) begin
      armed = 1;
      mode = MIdle;
      script.delete();
      seq.delete();
      lvl = 0;
      idx = 0;
      capNow = 0;
    end else begin
      if (start) begin
        seq.delete();
        lvl = 0;
        capNow = 0;
        newRound();
      end else if (mode == MRun && capNow) begin
        seq.push_back(mapDigit(int'(rngDigit)));
        lvl++;
        foreach (seq[i]) begin
          repeat (ShowC) script.push_back(seq[i]);
          repeat (GapC) script.push_back(KGap);
        end
        capNow = 0;
      end else if (mode == MInput && player_valid) begin
        if (int'(player_digit) != seq[idx]) mode = MFail;
        else if (idx == lvl - 1) begin
          pulse = 1;
          if (lvl == int'(MaxLen)) mode = MWin;
          else newRound();
        end else idx++;
      end
      if (mode == MRun) begin
        if (script.size() > 0) begin
          cur = script.pop_front();
          capNow = (cur == KCap);
        end else begin
          mode = MInput;
          idx = 0;
        end
      end
    end
  end

  // Every-cycle comparison of the full output bundle against the model.
  always @(negedge clk) begin
    if (armed) begin
      logic [15:0] got, exp;
      logic [3:0]  ed;
      ed  = (mode == MRun && cur >= 0) ? 4'(cur) : 4'd0;
      got = {3'd0, rngFetchSignal, show_en, show_digit, input_ready, level, round_ok, fail, win};
      exp = {3'd0, (mode == MRun && cur == KFetch), (mode == MRun && cur >= 0), ed,
             (mode == MInput), LenW'(lvl), pulse, (mode == MFail), (mode == MWin)};
      check("cycle_outputs", got, exp);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic key(logic [3:0] d);
    player_valid = 1'b1;
    player_digit = d;
    step();
    player_valid = 1'b0;
  endtask

  task automatic keyRound();
    int n = lvl;
    for (int i = 0; i < n; i++) key(4'(seq[i]));
  endtask

  task automatic waitInput(string name);
    int k = 0;
    while (mode != MInput && k < 200) begin
      step();
      k++;
    end
    if (mode != MInput) begin
      vectors++;
      miscompares++;
      $display("FAIL %s: got no input phase, expected one within 200 cycles", name);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    // Reset with player strobes that must be ignored.
    for (int i = 0; i < 3; i++) begin
      step();
      player_valid = ~player_valid;
      player_digit = 4'($urandom);
    end
    player_valid = 1'b0;
    check("reset_outputs", {rngFetchSignal, show_en, show_digit, input_ready, level,
                            round_ok, fail, win}, 16'd0);
    rst = 1'b1;
    step();
    key(4'd5);
    check("idle_ignores_valid", {input_ready, level, fail, win}, 16'd0);

    // Directed game: first digit 0xC, full timeline, then win at MaxLen.
    rngQ.push_back(12);
    start = 1'b1;
    step();
    start = 1'b0;
    check("fetch_pulse", {15'd0, rngFetchSignal}, 16'd1);
    step();
    check("fetch_single", {15'd0, rngFetchSignal}, 16'd0);
    step();
    check("first_show", {11'd0, show_en, show_digit}, {11'd0, 1'b1, CExp});
    repeat (ShowC - 1) step();
    check("show_last_cycle", {15'd0, show_en}, 16'd1);
    step();
    check("gap_first_cycle", {15'd0, show_en}, 16'd0);
    repeat (GapC) step();
    check("input_ready_l1", {13'd0, input_ready, level}, {13'd0, 1'b1, 2'd1});
    keyRound();
    check("round_ok_fetch", {14'd0, round_ok, rngFetchSignal}, 16'd3);
    waitInput("wait_round2");
    check("level_2", {14'd0, level}, 16'd2);
    keyRound();
    waitInput("wait_round3");
    keyRound();
    check("win_state", {12'd0, round_ok, win, level}, {12'd0, 1'b1, 1'b1, 2'd3});
    repeat (10) step();
    check("win_held", {13'd0, win, rngFetchSignal, input_ready}, 16'd4);

    // Wrong second entry in round 2, later strobes ignored, then restart.
    start = 1'b1;
    step();
    start = 1'b0;
    waitInput("wait_g2_r1");
    keyRound();
    waitInput("wait_g2_r2");
    key(4'(seq[0]));
    key(4'((seq[1] + 1) % 16));
    check("fail_set", {14'd0, fail, input_ready}, 16'd2);
    key(4'(seq[0]));
    key(4'(seq[1]));
    check("fail_held", {13'd0, fail, level}, {13'd0, 1'b1, 2'd2});
    start = 1'b1;
    step();
    start = 1'b0;
    check("fail_cleared", {12'd0, fail, level, rngFetchSignal}, 16'd1);

    // Start during replay aborts it.
    begin
      int k = 0;
      while (!show_en && k < 50) begin
        step();
        k++;
      end
      check("reached_show", {15'd0, show_en}, 16'd1);
    end
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("show_abort", {12'd0, show_en, level, rngFetchSignal}, 16'd1);

    // Start and a wrong strobe together: start wins.
    waitInput("wait_simul");
    player_valid = 1'b1;
    player_digit = 4'((seq[0] + 1) % 16);
    start = 1'b1;
    step();
    start = 1'b0;
    player_valid = 1'b0;
    check("start_beats_valid", {14'd0, fail, rngFetchSignal}, 16'd1);

    // Randomized play with occasional resets, restarts and bad keys.
    for (int c = 0; c < 5000; c++) begin
      r = $urandom_range(0, 999);
      start = 1'b0;
      player_valid = 1'b0;
      rst = 1'b1;
      if (r < 5) rst = 1'b0;
      else if (r < 15 || ((mode == MIdle || mode == MFail || mode == MWin) && r < 150)) begin
        start = 1'b1;
        player_valid = r[0];
        player_digit = 4'($urandom);
      end else if (mode == MInput && r < 700) begin
        player_valid = 1'b1;
        player_digit = 4'(seq[idx]);
      end else if (r > 960) begin
        player_valid = 1'b1;
        player_digit = 4'($urandom);
      end
      step();
    end
    start = 1'b0;
    player_valid = 1'b0;
    rst = 1'b1;
    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
